conv1x1_engine: RTL

//  Parametrised 1x1 (pointwise) convolution engine, successor to the fixed conv10 datapath. DSP_NO parallel signed MACs.

---
 rtl/conv1x1_engine.sv | 139 +++++++++++++
 1 files changed

// File: rtl/conv1x1_engine.sv
// Pointwise convolution: DSP_NO signed MAC lanes accumulate CHIN beats per output-channel group, then bias/requantise/saturate/ReLU.
// Result is registered 2 cycles after the last channel beat and held until out_ready; in_ready drops while a group is pending.
module conv1x1_engine #(
    parameter int WIDTH  = 16,
    parameter int DSP_NO = 64,
    parameter int CHIN   = 736,
    parameter int CHOUT  = 512,
    parameter int NPIX   = 64,
    parameter int SHIFT  = 15,
    parameter int ACC_W  = 40,
    localparam int NGRP  = CHOUT / DSP_NO,
    localparam int GW    = (NGRP > 1) ? $clog2(NGRP) : 1,
    localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1,
    localparam int CW    = (CHIN > 1) ? $clog2(CHIN) : 1,
    localparam int WA    = (NGRP * CHIN > 1) ? $clog2(NGRP * CHIN) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      relu_en,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    output logic [WA-1:0]             w_addr,
    input  logic [DSP_NO*WIDTH-1:0]   w_data,
    output logic [GW-1:0]             b_addr,
    input  logic [DSP_NO*2*WIDTH-1:0] b_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DSP_NO*WIDTH-1:0]   out_data,
    output logic [PW-1:0]             out_pix,
    output logic [GW-1:0]             out_grp,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

    localparam logic [CW-1:0] CH_LAST = CW'(CHIN - 1);
    localparam logic [GW-1:0] G_LAST  = GW'(NGRP - 1);
    localparam logic [PW-1:0] P_LAST  = PW'(NPIX - 1);
    localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

    state_t state, state_n;
    logic            relu_q;
    logic [PW-1:0]   pix;
    logic [GW-1:0]   grp;
    logic [CW-1:0]   ch;
    logic signed [ACC_W-1:0]   acc     [DSP_NO];
    logic signed [2*WIDTH-1:0] prod    [DSP_NO];
    logic signed [ACC_W:0]     biased  [DSP_NO];
    logic signed [ACC_W:0]     shifted [DSP_NO];
    logic [WIDTH-1:0]          res     [DSP_NO];
    logic beat, hs, last;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign beat      = in_valid && (state == ACCUM);
    assign hs        = out_ready && (state == OUT);
    assign last      = (pix == P_LAST) && (grp == G_LAST);
    assign w_addr    = WA'(grp * CHIN) + WA'(ch);
    assign b_addr    = grp;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = ACCUM;
            ACCUM:   if (in_valid && ch == CH_LAST) state_n = BIAS;
            BIAS:    state_n = OUT;
            OUT:     if (out_ready) state_n = last ? IDLE : ACCUM;
            default: state_n = IDLE;
        endcase
    end

    // Bias is added at full accumulator width plus one guard bit before the floor shift.
    always_comb begin
        for (int i = 0; i < DSP_NO; i++) begin
            prod[i]    = $signed(in_data) * $signed(w_data[i*WIDTH +: WIDTH]);
            biased[i]  = (ACC_W+1)'(acc[i]) + (ACC_W+1)'($signed(b_data[i*2*WIDTH +: 2*WIDTH]));
            shifted[i] = biased[i] >>> SHIFT;
            if (shifted[i] > SAT_HI)
                res[i] = SAT_HI[WIDTH-1:0];
            else if (shifted[i] < SAT_LO)
                res[i] = SAT_LO[WIDTH-1:0];
            else
                res[i] = shifted[i][WIDTH-1:0];
            if (relu_q && shifted[i][ACC_W])
                res[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            relu_q   <= 1'b0;
            pix      <= '0;
            grp      <= '0;
            ch       <= '0;
            done     <= 1'b0;
            out_data <= '0;
            out_pix  <= '0;
            out_grp  <= '0;
            for (int i = 0; i < DSP_NO; i++) acc[i] <= '0;
        end else begin
            state <= state_n;
            done  <= hs && last;
            if (state == IDLE && start) begin
                relu_q <= relu_en;
                pix    <= '0;
                grp    <= '0;
                ch     <= '0;
                for (int i = 0; i < DSP_NO; i++) acc[i] <= '0;
            end
            if (beat) begin
                for (int i = 0; i < DSP_NO; i++) acc[i] <= acc[i] + ACC_W'(prod[i]);
                ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
            end
            if (state == BIAS) begin
                for (int i = 0; i < DSP_NO; i++) begin
                    out_data[i*WIDTH +: WIDTH] <= res[i];
                    acc[i] <= '0;
                end
                out_pix <= pix;
                out_grp <= grp;
            end
            if (hs) begin
                if (grp == G_LAST) begin
                    grp <= '0;
                    pix <= pix + 1'b1;
                end else begin
                    grp <= grp + 1'b1;
                end
            end
        end
    end

endmodule
